// File: rtl/wb_pkg.sv
// Shared writeback-stage types and default widths.
// Source select indices and the buffered retire entry layout.
package wb_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ENC_W   = 3;
   localparam int DEF_WE_W    = 2;
   localparam int DEF_NUM_SRC = 3;
   localparam int DEF_CNT_W   = 16;

   localparam int SRC_MOVE  = 0;
   localparam int SRC_MEM   = 1;
   localparam int SRC_ARITH = 2;

   typedef struct packed {
      logic [DEF_WE_W-1:0]   we;
      logic [DEF_ENC_W-1:0]  enc;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_DATA_W-1:0] instr;
   } wb_entry_t;

endpackage

// File: rtl/wb_src_mux.sv
// One-hot writeback source mux with a select-error flag.
// A non-one-hot select yields zero data.
module wb_src_mux
   import wb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NUM_SRC = DEF_NUM_SRC
) (
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]        sel,
   output logic [DATA_W-1:0]         data_o,
   output logic                      onehot_err
);

   logic [DATA_W-1:0] or_data;
   logic [$clog2(NUM_SRC+1)-1:0] n_set;

   // OR together the selected slices and count select bits
   always_comb begin
      or_data = '0;
      n_set   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel[i]) begin
            or_data = or_data | src_data[i*DATA_W +: DATA_W];
            n_set   = n_set + 1'b1;
         end
      end
      onehot_err = (n_set != 1);
      data_o     = onehot_err ? '0 : or_data;
   end

endmodule

// File: rtl/instr_wb_buffered.sv
// Buffered writeback stage: 2-entry retire queue, retire counter.
// Optional WB_FWD_EN adds a forwarding lookup into the queue.
module instr_wb_buffered
   import wb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ENC_W   = DEF_ENC_W,
   parameter int WE_W    = DEF_WE_W,
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_instr,
   input  logic [WE_W-1:0]           in_regwrite,
   input  logic [ENC_W-1:0]          in_reg_enc,
   input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
   input  logic [NUM_SRC-1:0]        in_src_sel,
   input  logic                      rf_ready,
   output logic [WE_W-1:0]           rf_we,
   output logic [ENC_W-1:0]          rf_enc,
   output logic [DATA_W-1:0]         rf_data,
   output logic                      completed_valid,
   output logic [DATA_W-1:0]         completed_instr,
   output logic [CNT_W-1:0]          retire_count,
   output logic                      sel_err,
   input  logic [ENC_W-1:0]          fwd_query_enc,
   output logic                      fwd_hit,
   output logic [DATA_W-1:0]         fwd_data
);

   logic [DATA_W-1:0] mux_data;
   logic              mux_err;

   wb_src_mux #(
      .DATA_W  (DATA_W),
      .NUM_SRC (NUM_SRC)
   ) u_mux (
      .src_data   (in_src_data),
      .sel        (in_src_sel),
      .data_o     (mux_data),
      .onehot_err (mux_err)
   );

   logic [1:0]        count_q, count_d;
   logic [WE_W-1:0]   we_q    [2];
   logic [WE_W-1:0]   we_d    [2];
   logic [ENC_W-1:0]  enc_q   [2];
   logic [ENC_W-1:0]  enc_d   [2];
   logic [DATA_W-1:0] data_q  [2];
   logic [DATA_W-1:0] data_d  [2];
   logic [DATA_W-1:0] instr_q [2];
   logic [DATA_W-1:0] instr_d [2];

   logic              cv_q, cv_d;
   logic [DATA_W-1:0] ci_q, ci_d;
   logic [CNT_W-1:0]  rc_q, rc_d;
   logic              se_q, se_d;

   logic head_valid, push, pop, wr_idx;

   assign head_valid = (count_q != 2'd0);
   assign in_ready   = (count_q < 2'd2);
   assign push       = in_valid & in_ready;
   assign pop        = head_valid & rf_ready;
   // Push only happens below full, so the slot fits in one bit
   assign wr_idx     = pop ? 1'b0 : count_q[0];

   assign rf_we   = head_valid ? we_q[0]   : '0;
   assign rf_enc  = head_valid ? enc_q[0]  : '0;
   assign rf_data = head_valid ? data_q[0] : '0;

   assign completed_valid = cv_q;
   assign completed_instr = ci_q;
   assign retire_count    = rc_q;
   assign sel_err         = se_q;

   // Queue shift on pop, append on push, retire bookkeeping
   always_comb begin
      count_d = count_q;
      we_d    = we_q;
      enc_d   = enc_q;
      data_d  = data_q;
      instr_d = instr_q;
      cv_d    = pop;
      ci_d    = ci_q;
      rc_d    = rc_q;
      se_d    = se_q | (push & mux_err);
      if (pop) begin
         we_d[0]    = we_q[1];
         enc_d[0]   = enc_q[1];
         data_d[0]  = data_q[1];
         instr_d[0] = instr_q[1];
         count_d    = count_q - 2'd1;
         ci_d       = instr_q[0];
         rc_d       = rc_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (push) begin
         we_d[wr_idx]    = mux_err ? '0 : in_regwrite;
         enc_d[wr_idx]   = in_reg_enc;
         data_d[wr_idx]  = mux_data;
         instr_d[wr_idx] = in_instr;
         count_d         = count_d + 2'd1;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         cv_q    <= 1'b0;
         ci_q    <= '0;
         rc_q    <= '0;
         se_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            we_q[i]    <= '0;
            enc_q[i]   <= '0;
            data_q[i]  <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         cv_q    <= cv_d;
         ci_q    <= ci_d;
         rc_q    <= rc_d;
         se_q    <= se_d;
         we_q    <= we_d;
         enc_q   <= enc_d;
         data_q  <= data_d;
         instr_q <= instr_d;
      end
   end

`ifdef WB_FWD_EN
   // Youngest valid writing entry with matching register wins
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (count_q == 2'd2 && we_q[1] != '0 &&
          enc_q[1] == fwd_query_enc) begin
         fwd_hit  = 1'b1;
         fwd_data = data_q[1];
      end else if (head_valid && we_q[0] != '0 &&
                   enc_q[0] == fwd_query_enc) begin
         fwd_hit  = 1'b1;
         fwd_data = data_q[0];
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_query_enc;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_instr_wb_buffered.sv
// Directed self-checking bench for instr_wb_buffered.
// Build with +define+WB_FWD_EN to exercise forwarding.
module tb_instr_wb_buffered;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [1:0]  in_regwrite;
   logic [2:0]  in_reg_enc;
   logic [95:0] in_src_data;
   logic [2:0]  in_src_sel;
   logic        rf_ready;
   logic [1:0]  rf_we;
   logic [2:0]  rf_enc;
   logic [31:0] rf_data;
   logic        completed_valid;
   logic [31:0] completed_instr;
   logic [15:0] retire_count;
   logic        sel_err;
   logic [2:0]  fwd_query_enc;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_wb_buffered dut (
      .clk             (clk),
      .resetn          (resetn),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .in_regwrite     (in_regwrite),
      .in_reg_enc      (in_reg_enc),
      .in_src_data     (in_src_data),
      .in_src_sel      (in_src_sel),
      .rf_ready        (rf_ready),
      .rf_we           (rf_we),
      .rf_enc          (rf_enc),
      .rf_data         (rf_data),
      .completed_valid (completed_valid),
      .completed_instr (completed_instr),
      .retire_count    (retire_count),
      .sel_err         (sel_err),
      .fwd_query_enc   (fwd_query_enc),
      .fwd_hit         (fwd_hit),
      .fwd_data        (fwd_data)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one entry; the data goes to the source named by src_idx,
   // the other sources carry distinct junk values.
   task automatic drive(input logic [2:0] sel, input int src_idx,
                        input wb_entry_t e);
      in_valid    = 1'b1;
      in_src_sel  = sel;
      in_regwrite = e.we;
      in_reg_enc  = e.enc;
      in_instr    = e.instr;
      in_src_data = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
      in_src_data[src_idx*32 +: 32] = e.data;
   endtask

   task automatic chk_head(input string tag, input wb_entry_t e);
      check({tag, ".we"},   64'(rf_we),   64'(e.we));
      check({tag, ".enc"},  64'(rf_enc),  64'(e.enc));
      check({tag, ".data"}, 64'(rf_data), 64'(e.data));
   endtask

   wb_entry_t ea, eb, ec, ex;

   initial begin
      resetn        = 1'b0;
      in_valid      = 1'b0;
      in_instr      = '0;
      in_regwrite   = '0;
      in_reg_enc    = '0;
      in_src_data   = '0;
      in_src_sel    = '0;
      rf_ready      = 1'b0;
      fwd_query_enc = '0;
      #12;
      check("rst.rf_we",   64'(rf_we), 0);
      check("rst.rf_data", 64'(rf_data), 0);
      check("rst.cv",      64'(completed_valid), 0);
      check("rst.cnt",     64'(retire_count), 0);
      check("rst.sel_err", 64'(sel_err), 0);
      check("rst.fwd_hit", 64'(fwd_hit), 0);
      resetn = 1'b1;
      #3;
      step();
      check("rst.in_ready", 64'(in_ready), 1);

      // single accept via arithmetic source
      ea = '{we: 2'b11, enc: 3'd5, data: 32'h1234, instr: 32'hAAAA_0001};
      rf_ready = 1'b1;
      drive(3'b100, SRC_ARITH, ea);
      step();
      in_valid = 1'b0;
      chk_head("single", ea);
      check("single.cv0", 64'(completed_valid), 0);
      step();
      check("single.cv",    64'(completed_valid), 1);
      check("single.ci",    64'(completed_instr), 64'h AAAA_0001);
      check("single.cnt",   64'(retire_count), 1);
      check("single.empty", 64'(rf_we), 0);
      step();
      check("single.cv_end", 64'(completed_valid), 0);

      // backpressure: third entry waits for space
      rf_ready = 1'b0;
      ea = '{we: 2'b01, enc: 3'd1, data: 32'h0000_00A1, instr: 32'h1};
      eb = '{we: 2'b10, enc: 3'd2, data: 32'h0000_00B2, instr: 32'h2};
      ec = '{we: 2'b11, enc: 3'd3, data: 32'h0000_00C3, instr: 32'h3};
      drive(3'b001, SRC_MOVE, ea);
      step();
      check("bp.ready1", 64'(in_ready), 1);
      drive(3'b010, SRC_MEM, eb);
      step();
      check("bp.ready2", 64'(in_ready), 0);
      chk_head("bp.hold", ea);
      drive(3'b100, SRC_ARITH, ec);
      step();
      check("bp.full", 64'(in_ready), 0);
      check("bp.nocv", 64'(completed_valid), 0);
      chk_head("bp.stable", ea);
      rf_ready = 1'b1;
      step();
      check("bp.cvA", 64'(completed_valid), 1);
      check("bp.ciA", 64'(completed_instr), 1);
      chk_head("bp.headB", eb);
      check("bp.ready3", 64'(in_ready), 1);
      step();
      in_valid = 1'b0;
      check("bp.ciB", 64'(completed_instr), 2);
      chk_head("bp.headC", ec);
      step();
      check("bp.ciC", 64'(completed_instr), 3);
      check("bp.cnt", 64'(retire_count), 4);
      check("bp.empty", 64'(rf_we), 0);

      // simultaneous accept and pop at count=1
      rf_ready = 1'b0;
      ex = '{we: 2'b11, enc: 3'd7, data: 32'h100, instr: 32'h5000};
      drive(3'b100, SRC_ARITH, ex);
      step();
      rf_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         ex = '{we: 2'b11, enc: 3'(i), data: 32'h100 + i,
                instr: 32'h5000 + i};
         drive(3'b100, SRC_ARITH, ex);
         step();
         check("flow.data",  64'(rf_data), 64'(32'h100 + i));
         check("flow.ready", 64'(in_ready), 1);
         check("flow.cv",    64'(completed_valid), 1);
      end
      in_valid = 1'b0;
      step();
      check("flow.cnt", 64'(retire_count), 15);
      check("flow.ci",  64'(completed_instr), 64'h500A);

      // bad select: both move and mem bits
      ex = '{we: 2'b11, enc: 3'd6, data: 32'h77, instr: 32'h6000};
      drive(3'b011, SRC_MEM, ex);
      step();
      in_valid = 1'b0;
      check("bad.we",   64'(rf_we), 0);
      check("bad.data", 64'(rf_data), 0);
      check("bad.enc",  64'(rf_enc), 6);
      check("bad.err",  64'(sel_err), 1);
      step();
      check("bad.retire", 64'(retire_count), 16);
      for (int i = 0; i < 20; i++) begin
         ex = '{we: 2'b01, enc: 3'd2, data: 32'(i), instr: 32'h7000};
         drive(3'b001, SRC_MOVE, ex);
         step();
      end
      check("bad.sticky", 64'(sel_err), 1);
      // zero select also zeroes the write
      ex = '{we: 2'b11, enc: 3'd3, data: 32'h99, instr: 32'h8000};
      drive(3'b000, SRC_MOVE, ex);
      step();
      in_valid = 1'b0;
      check("zero.we",   64'(rf_we), 0);
      check("zero.data", 64'(rf_data), 0);
      step();
      check("bad.cnt", 64'(retire_count), 37);

      // async reset with two entries buffered
      rf_ready = 1'b0;
      ea = '{we: 2'b11, enc: 3'd4, data: 32'hA, instr: 32'h9001};
      eb = '{we: 2'b11, enc: 3'd4, data: 32'hB, instr: 32'h9002};
      drive(3'b010, SRC_MEM, ea);
      step();
      drive(3'b010, SRC_MEM, eb);
      step();
      in_valid = 1'b0;
      check("pre.ready", 64'(in_ready), 0);
      #2;
      resetn = 1'b0;
      #1;
      check("arst.we",   64'(rf_we), 0);
      check("arst.data", 64'(rf_data), 0);
      check("arst.cnt",  64'(retire_count), 0);
      check("arst.err",  64'(sel_err), 0);
      check("arst.ci",   64'(completed_instr), 0);
      rf_ready = 1'b1;
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post.we", 64'(rf_we), 0);
         check("post.cv", 64'(completed_valid), 0);
      end

      // forwarding lookup
      rf_ready = 1'b0;
      drive(3'b010, SRC_MEM, ea);
      step();
      drive(3'b010, SRC_MEM, eb);
      step();
      in_valid = 1'b0;
      fwd_query_enc = 3'd4;
      #1;
`ifdef WB_FWD_EN
      check("fwd.hit4",  64'(fwd_hit), 1);
      check("fwd.data4", 64'(fwd_data), 64'hB);
`else
      check("fwd.off4",  64'(fwd_hit), 0);
      check("fwd.offd",  64'(fwd_data), 0);
`endif
      fwd_query_enc = 3'd6;
      #1;
      check("fwd.hit6",  64'(fwd_hit), 0);
      check("fwd.data6", 64'(fwd_data), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
